neuron_timestep_scheduler: RTL and testbench
============================================

# neuron_timestep_scheduler

Sequences one shared `potential_adder` datapath across `NUM_NEURONS` neurons for each SNN timestep. It holds the membrane-potential register file and fetches each neuron's accumulated input weight through a request/valid handshake. It routes the stored potential through the external decay unit and drives the adder operands and `clear`. It writes the adder result back and produces a registered spike vector plus a `done` pulse per timestep.

## Interface
Parameters:
- `NUM_NEURONS`, 8: neurons served per timestep; must be ≥2.
- `IDX_W`, 3: neuron index width, equal to clog2(NUM_NEURONS).

Ports:
- `CLK` in 1: clock; all state updates on posedge.
- `RESET` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a timestep; ignored while `busy`.
- `v_threshold` in 32: IEEE-754 single threshold; latched on accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`, inclusive.
- `done` out 1: one-cycle pulse at the end of a timestep.
- `spikes` out NUM_NEURONS: bit i is the spike result of neuron i for the last timestep.
- `weight_req` out 1: request for the accumulated weight of `weight_idx`.
- `weight_idx` out IDX_W: neuron index being served.
- `weight_valid` in 1: `weight_sum` valid; sampled only while `weight_req` is high.
- `weight_sum` in 32: float accumulated input weight.
- `decay_in` out 32: stored potential of the current neuron, fed to the decay unit.
- `decay_out` in 32: decayed potential, combinational from `decay_in`.
- `adder_clear` out 1: drives adder `clear`.
- `adder_threshold` out 32: latched threshold.
- `adder_weight` out 32: captured `weight_sum`.
- `adder_decayed` out 32: captured `decay_out`.
- `adder_potential` in 32: adder `final_potential`.
- `adder_spike` in 1: adder `spike`.

## Operation
- Storage:
  - `pot[0..NUM_NEURONS-1]`, 32-bit each.
  - Index counter `idx`.
  - Operand registers for weight and decay.
  - Threshold register.
  - `spikes` register.
- FSM states are IDLE, FETCH, WAIT_W, ADD and DONE.
- IDLE: on `start`, latch `v_threshold`, clear `spikes` to 0, set `idx`=0, go to FETCH.
- FETCH: present `decay_in`=`pot[idx]` and capture `decay_out` into the decay operand. Go to WAIT_W.
- WAIT_W:
  - Assert `weight_req` with `weight_idx`=`idx`.
  - On `weight_valid`=1, capture `weight_sum` and go to ADD.
  - Otherwise hold, with no timeout.
- ADD:
  - `adder_clear`=0, so the adder output is used.
  - Write `pot[idx]` = 32'h00000000 if `adder_spike`, else `adder_potential`. This is reset-to-zero after a spike.
  - Set `spikes[idx]` = `adder_spike`.
  - If `idx`==NUM_NEURONS-1, go to DONE; else increment `idx` and go to FETCH.
- DONE: pulse `done`, then go to IDLE.
- `adder_clear`=1 in every state except ADD.
- `adder_threshold`, `adder_weight` and `adder_decayed` come directly from their registers.
- No arithmetic is performed here; all float math is in the adder and the decay unit.
- Boundary conditions:
  - `start` outside IDLE is ignored, with no queuing.
  - `start` in the same cycle as `done` is ignored. The earliest accepted `start` comes the cycle after `done`.
  - `weight_valid` outside WAIT_W is ignored.
  - `idx` never wraps past NUM_NEURONS-1 within a timestep.
  - `RESET` mid-timestep: next state IDLE, all `pot` zeroed, `spikes` zeroed, no `done` pulse.
  - `spikes` and `pot` persist across timesteps, except that `spikes` is cleared on `start`.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `spikes`=0, `weight_req`=0, `weight_idx`=0, `adder_clear`=1.
  - `adder_threshold`=0, `adder_weight`=0, `adder_decayed`=0, `decay_in`=0, all `pot`=0.
- Handshake: `weight_req` rises the cycle after FETCH. With `weight_valid` returned in the first cycle of `weight_req`, each neuron takes 3 cycles (FETCH, WAIT_W, ADD).
- Minimum timestep: `start` accepted at cycle 0, `done` high at cycle 3·NUM_NEURONS+1. For the default that is cycle 25.
- Each added cycle of `weight_valid` delay adds exactly one cycle.
- `spikes[i]` updates at the clock edge that ends neuron i's ADD cycle and is stable by the time `done` is high.
- `busy`=1 from cycle 1 through the `done` cycle.

## Test plan
- Reset, then `start` with `v_threshold`=0x41880000 (17.0), `weight_sum`=0x41200000 (10.0) immediate, decay model returning 0x40B00000 (5.5) → every `pot`=0x41780000, `spikes`=0, `done` at cycle 25.
- Same setup but `weight_sum`=0x41400000 (12.0) for neuron 3 only → `spikes`=8'b00001000, `pot[3]`=0, others 0x41780000.
- `weight_valid` delayed 2 cycles for neuron 5 → `weight_req` held 3 cycles on idx 5, `done` at cycle 27, results unchanged.
- `start` pulsed at cycles 4 and at the `done` cycle → both ignored; `start` one cycle after `done` begins a new timestep with `spikes` cleared.
- `RESET` asserted during neuron 4 of a timestep → next cycle IDLE, `busy`=0, `spikes`=0, no `done`, and the next timestep reads `pot`=0 via `decay_in`.
- Spurious `weight_valid` pulses in IDLE and FETCH → no state change, and captured `adder_weight` matches the WAIT_W-cycle `weight_sum`.

Source files
------------

// File: rtl/neuron_timestep_scheduler.sv
// Time-multiplexes one potential_adder across all neurons of a timestep,
// owning the membrane-potential file and the weight fetch handshake.
//
// state    | meaning
// ---------+-------------------------------------------------------
// S_IDLE   | waiting for start; outputs quiescent, adder cleared
// S_FETCH  | pot[idx] on decay_in, decayed value captured
// S_WAIT_W | weight_req high until weight_valid, weight captured
// S_ADD    | adder live; result and spike written back for idx
// S_DONE   | one-cycle done pulse, back to idle
module neuron_timestep_scheduler #(
   parameter int NUM_NEURONS = 8,
   parameter int IDX_W       = 3
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   start,
   input  logic [31:0]            v_threshold,
   output logic                   busy,
   output logic                   done,
   output logic [NUM_NEURONS-1:0] spikes,
   output logic                   weight_req,
   output logic [IDX_W-1:0]       weight_idx,
   input  logic                   weight_valid,
   input  logic [31:0]            weight_sum,
   output logic [31:0]            decay_in,
   input  logic [31:0]            decay_out,
   output logic                   adder_clear,
   output logic [31:0]            adder_threshold,
   output logic [31:0]            adder_weight,
   output logic [31:0]            adder_decayed,
   input  logic [31:0]            adder_potential,
   input  logic                   adder_spike
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT_W,
      S_ADD,
      S_DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [31:0]            thr_q, thr_d;
   logic [31:0]            weight_q, weight_d;
   logic [31:0]            decayed_q, decayed_d;
   logic [NUM_NEURONS-1:0] spikes_q, spikes_d;
   logic [31:0]            pot_q [NUM_NEURONS];
   logic [31:0]            pot_d [NUM_NEURONS];

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      thr_d     = thr_q;
      weight_d  = weight_q;
      decayed_d = decayed_q;
      spikes_d  = spikes_q;
      pot_d     = pot_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               thr_d    = v_threshold;
               spikes_d = '0;
               idx_d    = '0;
               state_d  = S_FETCH;
            end
         end
         S_FETCH: begin
            decayed_d = decay_out;
            state_d   = S_WAIT_W;
         end
         S_WAIT_W: begin
            if (weight_valid) begin
               weight_d = weight_sum;
               state_d  = S_ADD;
            end
         end
         S_ADD: begin
            // a spiking neuron resets its membrane potential to zero
            pot_d[idx_q]    = adder_spike ? 32'h0000_0000 : adder_potential;
            spikes_d[idx_q] = adder_spike;
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_FETCH;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         thr_q     <= '0;
         weight_q  <= '0;
         decayed_q <= '0;
         spikes_q  <= '0;
         for (int i = 0; i < NUM_NEURONS; i++) pot_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         thr_q     <= thr_d;
         weight_q  <= weight_d;
         decayed_q <= decayed_d;
         spikes_q  <= spikes_d;
         pot_q     <= pot_d;
      end
   end

   assign busy            = (state_q != S_IDLE);
   assign done            = (state_q == S_DONE);
   assign spikes          = spikes_q;
   assign weight_req      = (state_q == S_WAIT_W);
   assign weight_idx      = idx_q;
   assign decay_in        = pot_q[idx_q];
   assign adder_clear     = (state_q != S_ADD);
   assign adder_threshold = thr_q;
   assign adder_weight    = weight_q;
   assign adder_decayed   = decayed_q;

endmodule

// File: tb/tb_neuron_timestep_scheduler.sv
// Bench for neuron_timestep_scheduler: directed timesteps against a per-timestep
// schedule/result model, with stand-in decay unit and adder.
module tb_neuron_timestep_scheduler;
   localparam int          N     = 8;
   localparam logic [31:0] DECAY = 32'h40B0_0000;
   localparam logic [31:0] W10   = 32'h4120_0000;
   localparam logic [31:0] W12   = 32'h4140_0000;
   localparam logic [31:0] THR   = 32'h4188_0000;
   localparam logic [31:0] JUNK  = 32'h7F7F_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [31:0]   v_threshold = '0;
   logic          busy, done, weight_req, weight_valid = 1'b0, adder_clear, adder_spike;
   logic [N-1:0]  spikes;
   logic [2:0]    weight_idx;
   logic [31:0]   weight_sum = '0, decay_in, decay_out;
   logic [31:0]   adder_threshold, adder_weight, adder_decayed, adder_potential;

   neuron_timestep_scheduler #(.NUM_NEURONS(N), .IDX_W(3)) dut (
      .CLK(clk), .RESET(rst), .start(start), .v_threshold(v_threshold),
      .busy(busy), .done(done), .spikes(spikes),
      .weight_req(weight_req), .weight_idx(weight_idx),
      .weight_valid(weight_valid), .weight_sum(weight_sum),
      .decay_in(decay_in), .decay_out(decay_out),
      .adder_clear(adder_clear), .adder_threshold(adder_threshold),
      .adder_weight(adder_weight), .adder_decayed(adder_decayed),
      .adder_potential(adder_potential), .adder_spike(adder_spike)
   );

   always #5 clk = ~clk;

   // Stand-in float adder for the only operand pairs used here; positive
   // floats order the same as their bit patterns, so >= on bits is a float >=.
   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      if (a == DECAY && b == W10) return 32'h4178_0000;
      if (a == DECAY && b == W12) return 32'h418C_0000;
      return 32'hFFFF_FFFF;
   endfunction

   assign decay_out       = DECAY;
   assign adder_potential = adder_clear ? 32'h0 : fadd(adder_decayed, adder_weight);
   assign adder_spike     = !adder_clear && (adder_potential >= adder_threshold);

   int n_cmp = 0, n_bad = 0;
   int off = 0, done_off = -1, prev_done_off = -1;
   bit act = 0, chk_idle = 0, spur = 0;
   int s_req [64], s_idx [64], s_fetch [64], s_add [64], s_nfin [64];
   int s_len = 0;
   int cur_d [N];
   logic [31:0] cur_w [N];
   logic [31:0] model_pot [N], pre_pot [N], new_pot [N];
   logic [31:0] cur_thr = '0;
   logic [N-1:0] exp_spikes = '0, idle_spikes = '0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (offset %0d, t=%0t)", name, got, exp, off, $time);
      end
   endtask

   always @(negedge clk) begin
      if (act) begin
         chk("busy", busy, 32'(off != 0));
         chk("done", done, 32'(off == s_len));
         chk("weight_req", weight_req, 32'(s_req[off]));
         chk("adder_clear", adder_clear, 32'(s_add[off] < 0));
         if (off == 0) chk("spikes", spikes, idle_spikes);
         else chk("spikes", spikes, exp_spikes & N'((32'd1 << s_nfin[off]) - 1));
         if (s_req[off] != 0) chk("weight_idx", weight_idx, s_idx[off]);
         if (s_fetch[off] >= 0) chk("decay_in", decay_in, pre_pot[s_fetch[off]]);
         if (s_add[off] >= 0) begin
            chk("adder_weight", adder_weight, cur_w[s_add[off]]);
            chk("adder_decayed", adder_decayed, DECAY);
            chk("adder_threshold", adder_threshold, cur_thr);
         end
         if (done) done_off = off;
      end else if (chk_idle) begin
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
         chk("idle_req", weight_req, 0);
         chk("idle_clear", adder_clear, 1);
         chk("idle_spikes", spikes, idle_spikes);
      end
   end

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         act = 0; start = 1'b0; rst = 1'b0;
         weight_valid = spur; weight_sum = JUNK;
      end
   endtask

   task automatic set_pattern(input int w12_at, input int d_at, input int d_val);
      for (int i = 0; i < N; i++) begin
         cur_w[i] = (i == w12_at) ? W12 : W10;
         cur_d[i] = (i == d_at) ? d_val : 0;
      end
   endtask

   task automatic run_ts(input logic [31:0] thr, input int rst_at, input bit xstarts);
      int t, cnt;
      logic [31:0] sum;
      @(posedge clk); #1;
      prev_done_off = done_off;
      done_off = -1;
      for (int k = 0; k < 64; k++) begin
         s_req[k] = 0; s_idx[k] = 0; s_fetch[k] = -1; s_add[k] = -1; s_nfin[k] = 0;
      end
      t = 1;
      for (int i = 0; i < N; i++) begin
         s_fetch[t] = i;
         for (int j = 0; j <= cur_d[i]; j++) begin
            s_req[t+1+j] = 1; s_idx[t+1+j] = i;
         end
         s_add[t+2+cur_d[i]] = i;
         t += 3 + cur_d[i];
      end
      s_len = t;
      cnt = 0;
      for (int k = 0; k < 64; k++) begin
         s_nfin[k] = cnt;
         if (s_add[k] >= 0) cnt++;
      end
      exp_spikes = '0;
      for (int i = 0; i < N; i++) begin
         pre_pot[i] = model_pot[i];
         sum = fadd(DECAY, cur_w[i]);
         if (sum >= thr) begin
            exp_spikes[i] = 1'b1; new_pot[i] = 32'h0;
         end else begin
            new_pot[i] = sum;
         end
      end
      cur_thr = thr;
      act = 1; off = 0; start = 1'b1; v_threshold = thr;
      weight_valid = spur; weight_sum = JUNK;
      for (int k = 1; k <= s_len; k++) begin
         @(posedge clk); #1;
         if (k == rst_at + 1) begin
            rst = 1'b0; act = 0; idle_spikes = '0; start = 1'b0;
            for (int i = 0; i < N; i++) model_pot[i] = 32'h0;
            return;
         end
         off = k;
         start = xstarts && (k == 4 || k == s_len);
         v_threshold = 32'h0000_0001;
         rst = (k == rst_at);
         if (s_req[k] != 0 && s_add[k+1] >= 0) begin
            weight_valid = 1'b1; weight_sum = cur_w[s_idx[k]];
         end else begin
            weight_valid = spur && (s_fetch[k] >= 0); weight_sum = JUNK;
         end
      end
      for (int i = 0; i < N; i++) model_pot[i] = new_pot[i];
      idle_spikes = exp_spikes;
   endtask

   initial begin
      for (int i = 0; i < N; i++) model_pot[i] = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_spikes", spikes, 0);
      chk("rst_req", weight_req, 0);
      chk("rst_idx", weight_idx, 0);
      chk("rst_clear", adder_clear, 1);
      chk("rst_thr", adder_threshold, 0);
      chk("rst_weight", adder_weight, 0);
      chk("rst_decayed", adder_decayed, 0);
      chk("rst_decay_in", decay_in, 0);
      chk_idle = 1;
      idle(2);

      set_pattern(-1, -1, 0);
      run_ts(THR, -1, 0);
      idle(2);
      chk("done_cycle_A", done_off, 25);
      chk("model_pot0_A", model_pot[0], 32'h4178_0000);

      set_pattern(3, -1, 0);
      run_ts(THR, -1, 0);
      idle(1);
      chk("spikes_B", spikes, 32'h08);
      chk("model_pot3_B", model_pot[3], 32'h0);

      set_pattern(3, 5, 2);
      run_ts(THR, -1, 1);
      set_pattern(-1, -1, 0);
      run_ts(THR, -1, 0);
      idle(2);
      chk("done_cycle_C", prev_done_off, 27);
      chk("done_cycle_D", done_off, 25);

      spur = 1;
      set_pattern(-1, 2, 1);
      idle(2);
      run_ts(THR, -1, 0);
      idle(2);
      spur = 0;
      chk("done_cycle_E", done_off, 26);

      set_pattern(-1, -1, 0);
      run_ts(THR, 13, 0);
      idle(3);
      chk("reset_no_done", done_off, -1);
      chk("reset_thr", adder_threshold, 0);
      chk("reset_weight", adder_weight, 0);

      set_pattern(6, -1, 0);
      run_ts(THR, -1, 0);
      idle(2);
      chk("spikes_G", spikes, 32'h40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
